// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : bram_stream_reader
//  Purpose  : Drains a contiguous BRAM window onto a valid/ready stream,
//             using a 2-entry skid buffer to absorb single-cycle read latency.
//  Revision : 1.0  initial release
// ============================================================================
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 12,
  parameter int BIT_WIDTH  = 32,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_re,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  input  logic [BIT_WIDTH-1:0]  bram_rdo,
  output logic                  m_tvalid,
  output logic [BIT_WIDTH-1:0]  m_tdata,
  output logic                  m_tlast,
  input  logic                  m_tready
);

  localparam logic [LEN_WIDTH-1:0] c_len_one = LEN_WIDTH'(1);
  localparam logic [1:0]           c_depth   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [ADDR_WIDTH-1:0]  r_base;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [LEN_WIDTH-1:0]   r_issued;
  logic [LEN_WIDTH-1:0]   r_sent;
  logic                   r_inflight;

  logic [BIT_WIDTH-1:0]   r_mem [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;

  logic                   w_accept;
  logic                   w_issue;
  logic                   w_pop;
  logic                   w_push;
  logic [2:0]             w_occ;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_pop    = m_tvalid && m_tready;
  assign w_push   = r_inflight;

  // Occupancy the buffer will have once this cycle's pop retires; a new read
  // may only be launched if its data is guaranteed a free slot on arrival.
  assign w_occ    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  // ---------------------------------------------------------------- FSM comb
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_issue = (r_issued < r_len) && (w_occ < {1'b0, c_depth});
        if (w_pop && m_tlast) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------------- FSM reg
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ------------------------------------------------------- burst bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_sent     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_base   <= base_addr;
        r_len    <= length;
        r_issued <= '0;
        r_sent   <= '0;
      end else begin
        if (w_issue) begin
          r_issued <= r_issued + c_len_one;
        end
        if (w_pop) begin
          r_sent <= r_sent + c_len_one;
        end
      end
    end
  end

  // -------------------------------------------------------- 2-entry buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bram_rdo;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ----------------------------------------------------------------- outputs
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign bram_re    = w_issue;
  assign bram_raddr = r_base + ADDR_WIDTH'(r_issued);
  assign m_tvalid   = (r_count != 2'd0);
  assign m_tdata    = r_mem[r_rd_ptr];
  // Words leave strictly in order, so the head is word index r_sent.
  assign m_tlast    = m_tvalid && (r_sent == (r_len - c_len_one));

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_stream_reader
//  Purpose  : Directed self-checking bench for bram_stream_reader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] base_addr;
  logic [11:0] length;
  logic        busy;
  logic        done;
  logic        bram_re;
  logic [11:0] bram_raddr;
  logic [31:0] bram_rdo = '0;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tready;

  logic [31:0] mem [4096];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // BRAM model with one cycle read latency
  always @(posedge clk) begin
    if (bram_re) bram_rdo <= mem[bram_raddr];
  end

  bram_stream_reader #(
    .ADDR_WIDTH(12),
    .BIT_WIDTH (32),
    .LEN_WIDTH (12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bram_re   (bram_re),
    .bram_raddr(bram_raddr),
    .bram_rdo  (bram_rdo),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [11:0] a);
    return {20'hA0000, a};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full-throughput burst; optionally fires a competing start at cycle 2.
  task automatic run_full(input logic [11:0] base, input logic [11:0] len, input bit intrude);
    logic [11:0] ea;
    logic [11:0] da;
    start = 1'b1; base_addr = base; length = len; m_tready = 1'b1;
    @(negedge clk);
    check($sformatf("idle_busy b%0h", base), busy, 1'b0);
    next_cycle();
    base_addr = 12'hABC; length = 12'd7;
    for (int c = 1; c <= int'(len) + 3; c++) begin
      if (intrude && c == 2) begin
        start = 1'b1; base_addr = 12'h300; length = 12'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      ea = base + 12'(c - 1);
      da = base + 12'(c - 3);
      check($sformatf("busy b%0h c%0d", base, c), busy, 1'b1);
      check($sformatf("done b%0h c%0d", base, c), done, c == int'(len) + 3);
      check($sformatf("re b%0h c%0d", base, c), bram_re, c <= int'(len));
      if (c <= int'(len))
        check($sformatf("raddr b%0h c%0d", base, c), bram_raddr, ea);
      check($sformatf("tvalid b%0h c%0d", base, c), m_tvalid, (c >= 3) && (c <= int'(len) + 2));
      if (c >= 3 && c <= int'(len) + 2) begin
        check($sformatf("tdata b%0h c%0d", base, c), m_tdata, word_at(da));
        check($sformatf("tlast b%0h c%0d", base, c), m_tlast, c == int'(len) + 2);
      end
      next_cycle();
    end
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    logic [31:0] prev_data;
    logic        prev_last;
    bit          prev_stall;
    bit          got_done;
    int          n_re;
    int          n_pop;

    for (int i = 0; i < 4096; i++) mem[i] = word_at(12'(i));

    // ------------------------------------------------------------ reset
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_tready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_busy",   busy,       1'b0);
    check("rst_done",   done,       1'b0);
    check("rst_re",     bram_re,    1'b0);
    check("rst_raddr",  bram_raddr, 12'h000);
    check("rst_tvalid", m_tvalid,   1'b0);
    check("rst_tdata",  m_tdata,    32'h0);
    check("rst_tlast",  m_tlast,    1'b0);
    rst_n = 1'b1;
    next_cycle();

    // ------------------------------------------------------ basic burst
    run_full(12'h010, 12'd4, 1'b0);

    // ----------------------------------------------------- backpressure
    pat = 16'b1001_0110_0011_0101;
    start = 1'b1; base_addr = 12'h100; length = 12'd8; m_tready = 1'b0;
    next_cycle();
    start = 1'b0;
    n_re = 0; n_pop = 0; got_done = 1'b0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    for (int c = 1; c < 80 && !got_done; c++) begin
      m_tready = pat[c % 16];
      @(negedge clk);
      if (prev_stall) begin
        check($sformatf("bp_hold_valid c%0d", c), m_tvalid, 1'b1);
        check($sformatf("bp_hold_data c%0d", c),  m_tdata,  prev_data);
        check($sformatf("bp_hold_last c%0d", c),  m_tlast,  prev_last);
      end
      if (bram_re) begin
        check($sformatf("bp_raddr c%0d", c), bram_raddr, 12'h100 + 12'(n_re));
        n_re++;
      end
      if (m_tvalid && m_tready) begin
        check($sformatf("bp_tdata w%0d", n_pop), m_tdata, word_at(12'h100 + 12'(n_pop)));
        check($sformatf("bp_tlast w%0d", n_pop), m_tlast, n_pop == 7);
        n_pop++;
      end
      check($sformatf("bp_outstanding c%0d", c), (n_re - n_pop) <= 2, 1'b1);
      if (done) begin
        got_done = 1'b1;
        check("bp_words_at_done", n_pop, 8);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      next_cycle();
    end
    check("bp_done_seen", got_done, 1'b1);
    check("bp_reads",     n_re,     8);
    check("bp_words",     n_pop,    8);

    // ---------------------------------------------------- zero length
    start = 1'b1; base_addr = 12'h123; length = 12'd0; m_tready = 1'b1;
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    check("z_done_c1",   done,     1'b1);
    check("z_busy_c1",   busy,     1'b1);
    check("z_re_c1",     bram_re,  1'b0);
    check("z_tvalid_c1", m_tvalid, 1'b0);
    next_cycle();
    @(negedge clk);
    check("z_done_c2",   done,     1'b0);
    check("z_busy_c2",   busy,     1'b0);
    check("z_re_c2",     bram_re,  1'b0);
    check("z_tvalid_c2", m_tvalid, 1'b0);
    next_cycle();

    // ------------------------------------------- one word, wrap, intrude
    run_full(12'h020, 12'd1, 1'b0);
    run_full(12'hFFE, 12'd4, 1'b0);
    run_full(12'h200, 12'd6, 1'b1);
    run_full(12'h300, 12'd3, 1'b0);

    // ------------------------------------------------ reset mid-burst
    start = 1'b1; base_addr = 12'h040; length = 12'd6; m_tready = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) check("mr_second_word", m_tdata, word_at(12'h041));
      next_cycle();
    end
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_busy",   busy,       1'b0);
    check("mr_done",   done,       1'b0);
    check("mr_re",     bram_re,    1'b0);
    check("mr_raddr",  bram_raddr, 12'h000);
    check("mr_tvalid", m_tvalid,   1'b0);
    check("mr_tdata",  m_tdata,    32'h0);
    check("mr_tlast",  m_tlast,    1'b0);
    next_cycle();
    @(negedge clk);
    check("mr_no_done", done, 1'b0);
    next_cycle();
    run_full(12'h050, 12'd3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
